lock_key_loader: RTL



---
 rtl/lock_key_loader_pkg.sv | 19 +
 rtl/lock_key_gap_timer.sv | 27 ++
 rtl/lock_key_loader.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/lock_key_loader_pkg.sv
// Shared types and constants for the serial key-load controller.
package lock_key_loader_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        CHECK   = 2'd2,
        LOCKOUT = 2'd3
    } lk_state_e;

    localparam int unsigned DEFAULT_KEY_WIDTH = 10;
    localparam int unsigned DEFAULT_TIMEOUT   = 64;
    localparam int unsigned DEFAULT_MAX_FAIL  = 3;

    function automatic int unsigned fail_cnt_width(input int unsigned max_fail);
        return $clog2(max_fail + 1);
    endfunction

endpackage

// File: rtl/lock_key_gap_timer.sv
// Idle-gap counter for the SHIFT state; expire fires on the cycle whose edge reaches TIMEOUT.
module lock_key_gap_timer #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(TIMEOUT - 1);

    logic [CntW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt_q <= '0;
        end else if (enable) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expire = enable && (cnt_q == LastCnt);

endmodule

// File: rtl/lock_key_loader.sv
// Serial key loader: shifts a parity-protected key frame in and commits it atomically.
module lock_key_loader
    import lock_key_loader_pkg::*;
#(
    parameter int unsigned KEY_WIDTH = DEFAULT_KEY_WIDTH,
    parameter int unsigned TIMEOUT   = DEFAULT_TIMEOUT,
    parameter int unsigned MAX_FAIL  = DEFAULT_MAX_FAIL
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 load_start,
    input  logic                                 bit_in,
    input  logic                                 bit_valid,
    output logic                                 bit_ready,
    output logic [KEY_WIDTH-1:0]                 key_out,
    output logic                                 key_ready,
    output logic                                 busy,
    output logic                                 err_parity,
    output logic                                 err_timeout,
    output logic                                 locked_out,
    output logic [fail_cnt_width(MAX_FAIL)-1:0]  fail_cnt
);

    localparam int unsigned FailW = fail_cnt_width(MAX_FAIL);
    localparam int unsigned IdxW  = $clog2(KEY_WIDTH + 1);
    localparam logic [IdxW-1:0]  ParIdx  = IdxW'(KEY_WIDTH);
    localparam logic [FailW-1:0] FailMax = FailW'(MAX_FAIL);

    lk_state_e            state_q, state_d;
    logic [KEY_WIDTH-1:0] shadow_q, shadow_d;
    logic [IdxW-1:0]      idx_q, idx_d;
    logic                 par_q, par_d;
    logic [KEY_WIDTH-1:0] key_q, key_d;
    logic                 key_ready_q, key_ready_d;
    logic                 err_par_q, err_par_d;
    logic                 err_to_q, err_to_d;
    logic                 locked_q, locked_d;
    logic [FailW-1:0]     fail_q, fail_d;

    logic accept;
    logic timer_clear;
    logic timer_enable;
    logic timer_expire;

    assign bit_ready = (state_q == SHIFT);
    assign busy      = (state_q == SHIFT) || (state_q == CHECK);
    assign accept    = bit_ready && bit_valid;

    // A restart request overrides a bit accepted in the same cycle.
    assign timer_clear  = ((state_q == IDLE) && load_start) ||
                          ((state_q == SHIFT) && (accept || load_start));
    assign timer_enable = (state_q == SHIFT) && !accept && !load_start;

    lock_key_gap_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_gap_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (timer_clear),
        .enable (timer_enable),
        .expire (timer_expire)
    );

    always_comb begin
        state_d     = state_q;
        shadow_d    = shadow_q;
        idx_d       = idx_q;
        par_d       = par_q;
        key_d       = key_q;
        key_ready_d = key_ready_q;
        err_par_d   = 1'b0;
        err_to_d    = 1'b0;
        locked_d    = locked_q;
        fail_d      = fail_q;

        unique case (state_q)
            IDLE: begin
                if (load_start) begin
                    state_d  = SHIFT;
                    shadow_d = '0;
                    idx_d    = '0;
                    par_d    = 1'b0;
                end
            end
            SHIFT: begin
                if (load_start) begin
                    shadow_d = '0;
                    idx_d    = '0;
                    par_d    = 1'b0;
                end else if (accept) begin
                    par_d = par_q ^ bit_in;
                    if (idx_q == ParIdx) begin
                        state_d = CHECK;
                    end else begin
                        shadow_d[idx_q] = bit_in;
                        idx_d           = idx_q + 1'b1;
                    end
                end else if (timer_expire) begin
                    err_to_d = 1'b1;
                    state_d  = IDLE;
                end
            end
            CHECK: begin
                if (!par_q) begin
                    key_d       = shadow_q;
                    key_ready_d = 1'b1;
                    state_d     = IDLE;
                end else begin
                    err_par_d = 1'b1;
                    if (fail_q != FailMax) begin
                        fail_d = fail_q + 1'b1;
                    end
                    if (fail_d == FailMax) begin
                        state_d     = LOCKOUT;
                        key_d       = '0;
                        key_ready_d = 1'b0;
                        locked_d    = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            LOCKOUT: begin
                key_d       = '0;
                key_ready_d = 1'b0;
                locked_d    = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            shadow_q    <= '0;
            idx_q       <= '0;
            par_q       <= 1'b0;
            key_q       <= '0;
            key_ready_q <= 1'b0;
            err_par_q   <= 1'b0;
            err_to_q    <= 1'b0;
            locked_q    <= 1'b0;
            fail_q      <= '0;
        end else begin
            state_q     <= state_d;
            shadow_q    <= shadow_d;
            idx_q       <= idx_d;
            par_q       <= par_d;
            key_q       <= key_d;
            key_ready_q <= key_ready_d;
            err_par_q   <= err_par_d;
            err_to_q    <= err_to_d;
            locked_q    <= locked_d;
            fail_q      <= fail_d;
        end
    end

    assign key_out     = key_q;
    assign key_ready   = key_ready_q;
    assign err_parity  = err_par_q;
    assign err_timeout = err_to_q;
    assign locked_out  = locked_q;
    assign fail_cnt    = fail_q;

endmodule
